mux4_rr_arbiter: RTL
====================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum grant tenure in cycles (legal range 2..255), used only when ARB_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req  input  4  request from requester i on bit i, level-sensitive.
REQ-005 The block SHALL have port done  input  1  current owner releases the mux, sampled only while busy=1.
REQ-006 The block SHALL have port grant  output  4  one-hot registered grant, all-zero when idle.
REQ-007 The block SHALL have port sel  output  2  mux4to1 select, equal to the index of the granted requester.
REQ-008 The block SHALL have port busy  output  1  high while any grant is active.

Function
REQ-009 The block SHALL implement two states: IDLE (grant=0000, busy=0) and GRANT (grant one-hot, busy=1).
REQ-010 The block SHALL hold a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3 mod 4, and the first set req bit wins.
REQ-011 In IDLE, when req is non-zero at a rising edge, the block SHALL enter GRANT at that edge, so grant appears 1 cycle after req.
REQ-012 In IDLE with req=0000, the block SHALL stay in IDLE, and sel SHALL hold its last value.
REQ-013 In GRANT, the owner SHALL be released at an edge where done=1, or where req[owner]=0, or where a forced release occurs (REQ-019).
REQ-014 On release, ptr SHALL become owner+1 mod 4, with wrap 3->0.
REQ-015 On release, if the new search finds a request, the block SHALL issue the new grant at the same edge (back-to-back, no idle cycle); otherwise it SHALL go to IDLE.
REQ-016 In the new search, a releasing owner whose req is still high SHALL be lowest priority, because of the pointer rotation.
REQ-017 Simultaneous done=1 and req[owner]=0 SHALL count as a single release.
REQ-018 grant and sel SHALL change only at rising edges and never glitch between edges; sel SHALL update in the same cycle as grant.

Reset
REQ-019 (forced release, ARB_TIMEOUT_EN only) When hold_cnt reaches MAX_HOLD-1 and another req bit is set, the block SHALL release the owner at the next edge.
REQ-020 (forced release, ARB_TIMEOUT_EN only) If no other req bit is set, hold_cnt SHALL saturate at MAX_HOLD-1 and the grant SHALL continue.
REQ-021 While rst_n=0, independent of clk: grant=0000, sel=00, busy=0, ptr=00, hold_cnt=0, state=IDLE.
REQ-022 Reset asserted mid-grant SHALL drop grant within the same cycle, without waiting for done.
REQ-023 After rst_n deasserts, the first grant SHALL follow REQ-011 with ptr=0.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined, the block SHALL include an 8-bit hold_cnt that clears to 0 on every new grant and increments each GRANT cycle, and it SHALL enforce REQ-019 and REQ-020.
REQ-025 With ARB_TIMEOUT_EN undefined, hold_cnt and MAX_HOLD SHALL have no effect, and a grant SHALL end only by done or by the owner dropping req.

Verification
REQ-026 The bench SHALL apply reset, then req=0101 for one edge -> next cycle grant=0001, sel=00, busy=1.
REQ-027 The bench SHALL hold req=1111 and pulse done each grant -> grants 0001, 0010, 0100, 1000, 0001 on consecutive edges, sel 0,1,2,3,0, busy constantly 1.
REQ-028 The bench SHALL set owner=3, req=1000, then drop req to 0000 -> next edge grant=0000, busy=0, sel stays 11, and a later req=1001 grants 0001 (ptr wrapped to 0).
REQ-029 With ARB_TIMEOUT_EN and MAX_HOLD=4, the bench SHALL hold req=0011 with done=0 -> grant 0001 for 4 cycles, then 0010 for 4 cycles, alternating.
REQ-030 With ARB_TIMEOUT_EN and MAX_HOLD=4, the bench SHALL hold req=0001 alone for 10 cycles -> grant stays 0001 throughout.
REQ-031 The bench SHALL assert rst_n=0 mid-cycle during grant=0100 -> grant=0000, sel=00, busy=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter that owns the select of a 4:1 mux. One requester at a
// time holds the mux until it signals done or drops its request; on release
// the priority pointer moves past the old owner so every requester gets a
// turn. A new owner can be granted on the same edge as a release, so
// back-to-back tenures have no idle cycle in between.
//
// Optional feature (macro ARB_TIMEOUT_EN): an 8-bit tenure counter forces
// the owner off the mux after MAX_HOLD cycles, but only if somebody else is
// waiting. Without the macro, MAX_HOLD has no effect.
//
// Ports
//   clk    in   1  clock, all state updates on the rising edge
//   rst_n  in   1  asynchronous active-low reset
//   req    in   4  level-sensitive request, bit i = requester i
//   done   in   1  owner releases the mux (looked at only while busy)
//   grant  out  4  registered one-hot grant, 0000 when idle
//   sel    out  2  mux select = index of granted requester (holds when idle)
//   busy   out  1  high while a grant is active
//
// Handshake: a requester is served while grant[i]=1; the tenure ends at the
// first rising edge where done=1 or req[i]=0 (or a forced release), and a
// simultaneous done and req drop count as one release.
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;

    logic       force_rel;
    logic       new_grant;
    logic       owner_release;

    // First set request bit in the order p, p+1, p+2, p+3 (mod 4).
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            cand = p + 2'(i);
            if (!res[2] && r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    logic [1:0] rel_ptr;
    logic [2:0] pick_idle;
    logic [2:0] pick_rel;

    // On release the pointer moves one past the owner, which automatically
    // puts a still-requesting owner last in the new search.
    assign rel_ptr   = sel_q + 2'd1;
    assign pick_idle = rr_pick(ptr_q, req);
    assign pick_rel  = rr_pick(rel_ptr, req);

    assign owner_release = (state_q == ST_GRANT) && (done || !req[sel_q] || force_rel);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        new_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle[2]) begin
                    state_d   = ST_GRANT;
                    grant_d   = 4'b0001 << pick_idle[1:0];
                    sel_d     = pick_idle[1:0];
                    new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (owner_release) begin
                    ptr_d = rel_ptr;
                    if (pick_rel[2]) begin
                        grant_d   = 4'b0001 << pick_rel[1:0];
                        sel_d     = pick_rel[1:0];
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'b00;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       others_req;

    assign others_req = |(req & ~grant_q);
    // Counter sits at HOLD_LAST on the owner's last allowed cycle; the
    // release then happens on the following edge if anyone else waits.
    assign force_rel  = (state_q == ST_GRANT) && (hold_cnt_q == HOLD_LAST) && others_req;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant) begin
            hold_cnt_d = 8'd0;
        end else if ((state_q == ST_GRANT) && (hold_cnt_q < HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic unused_hold;
    assign force_rel   = 1'b0;
    assign unused_hold = ^{HOLD_LAST, new_grant};
`endif

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = (state_q == ST_GRANT);

endmodule
